alu_share_arbiter: RTL
======================

# alu_share_arbiter

Sequencer/arbiter sharing one combinational 4-bit ALU (NOT/AND/OR/ADD-style units, each producing OUT, Z, CF) between two requesters. Latches the granted requester's opcode and operands, drives the ALU, captures result and flags into registers, and returns them with a one-cycle DONE pulse. Sits between the two control sources (e.g. switch-input path and program sequencer) and the shared ALU datapath.

## Interface
- WIDTH, 4, operand/result width
- OPW, 3, opcode width (ALU unit select)

- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, synchronous, active-low
- REQ0 / REQ1  in  1  request from requester 0 / 1; held high until its DONE
- OP0 / OP1  in  OPW  opcode of requester 0 / 1
- A0, B0 / A1, B1  in  WIDTH  operands of requester 0 / 1
- DONE0 / DONE1  out  1  one-cycle completion pulse to requester 0 / 1
- RES  out  WIDTH  registered result of last completed op
- ZF  out  1  registered Z flag of last completed op (passed through as ALU defines it)
- CF  out  1  registered carry flag of last completed op
- BUSY  out  1  high whenever state is not IDLE
- ALU_OP  out  OPW  registered opcode to shared ALU
- ALU_IN1, ALU_IN2  out  WIDTH  registered operands to shared ALU
- ALU_OUT  in  WIDTH  ALU result (combinational from ALU_OP/ALU_IN*)
- ALU_Z, ALU_CF  in  1  ALU flags

## Operation
- States: IDLE, ISSUE, RESP. Encoding free; no other reachable states; any illegal state returns to IDLE next edge.
- IDLE: at each edge sample REQ0/REQ1. Neither high: stay. One high: grant it. Both high: grant the requester not served last (round robin, LAST register). On grant: load ALU_OP/ALU_IN1/ALU_IN2 from granted OPx/Ax/Bx, record grant ID, LAST := grant ID, go ISSUE.
- ISSUE: ALU inputs stable for the full cycle. At edge: RES := ALU_OUT, ZF := ALU_Z, CF := ALU_CF; assert DONEx for granted ID; go RESP.
- RESP: DONEx high this cycle only. At edge: DONEx := 0, go IDLE. REQ not sampled in RESP.
- Requester drops REQ during its DONE cycle; REQ still high at the first IDLE sampling edge is a new request.
- REQ dropped after grant but before DONE: operation completes, DONE still pulses (operands already latched).
- OPx/Ax/Bx changes after grant ignored for current op.
- RES/ZF/CF/ALU_* hold until next overwrite; no arithmetic performed here, widths pass straight through.
- Reset: state IDLE, LAST=1 (requester 0 wins first contest), ALU_OP/ALU_IN1/ALU_IN2=0, RES=0, ZF=0, CF=0, DONE0=DONE1=0, BUSY=0. Reset mid-operation aborts it: no DONE issued, requester must re-request.

## Timing
- Edge E0 (IDLE, REQ high) → ISSUE cycle; edge E1 → DONE + RES/ZF/CF valid in cycle after E1; edge E2 → IDLE. Latency REQ-sampled to DONE: 2 cycles.
- Earliest next sampling edge E3; max throughput one op per 3 cycles.
- DONE0 and DONE1 never high together. BUSY high from cycle after E0 through RESP cycle.
- ALU_OUT/ALU_Z/ALU_CF must settle within one cycle of ALU inputs.

## Configuration
- ALU_ARB_FIXED_PRIO_EN: defined → fixed priority, requester 0 always wins simultaneous requests; LAST unused. Undefined → round robin as above (default).

## Test plan
- Single REQ0, OP=NOT, A0=4'b0101: ALU_IN1=0101 in ISSUE cycle; with ALU returning 1010, DONE0 pulses 2 cycles after sampling edge, RES=1010, BUSY low again after RESP.
- REQ0 and REQ1 high together from reset, both held: served 0,1,0,1 alternately, DONE every 3 cycles; with ALU_ARB_FIXED_PRIO_EN and both held, only requester 0 served.
- Requester 0 keeps REQ0 high through DONE0, REQ1 pending: requester 1 served next, then requester 0 again.
- Change A0 from 0011 to 1111 during ISSUE: ALU_IN1 stays 0011, RES reflects 0011.
- Assert RSTN=0 during ISSUE: next cycle state IDLE, all outputs at reset values, no DONE; new REQ1 afterward served normally.
- ALU_Z=1, ALU_CF=1 at capture: ZF=1, CF=1 held through following idle cycles until next completion.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and returns registered results with a DONE pulse.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round robin.
module alu_share_arbiter #(
   parameter int WIDTH = 4,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0,
   input  logic             req1,
   input  logic [OPW-1:0]   op0,
   input  logic [OPW-1:0]   op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] res,
   output logic             zf,
   output logic             cf,
   output logic             busy,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   input  logic             alu_cf
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state;
   logic   gnt;
   logic   pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = !req0;
   end
`else
   logic last;

   // On a tie the requester that was not served last time wins.
   always_comb begin
      pick = req1;
      if (req0 && req1) begin
         pick = ~last;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         gnt     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last    <= 1'b1;
`endif
         alu_op  <= '0;
         alu_in1 <= '0;
         alu_in2 <= '0;
         res     <= '0;
         zf      <= 1'b0;
         cf      <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  alu_op  <= pick ? op1 : op0;
                  alu_in1 <= pick ? a1  : a0;
                  alu_in2 <= pick ? b1  : b0;
                  gnt     <= pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last    <= pick;
`endif
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               res   <= alu_out;
               zf    <= alu_z;
               cf    <= alu_cf;
               done0 <= !gnt;
               done1 <= gnt;
               state <= RESP;
            end
            RESP: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
